// File: rtl/ula_cmd_ctrl.sv
// Host-command sequencer for the ULA: flushes the selector, launches, waits for done.
// Define ULA_CTRL_WATCHDOG_EN to enable the per-operation timeout watchdog.
module ula_cmd_ctrl #(
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        abort,
  input  logic        ula_done,
  output logic [3:0]  ula_seletor,
  output logic        busy,
  output logic        done_pulse,
  output logic [1:0]  status,
  output logic [3:0]  last_op,
  output logic [23:0] cycle_count
);

  localparam logic [3:0] IdleCode  = 4'b0111;
  localparam logic [3:0] FlushLast = 4'(FLUSH_CYCLES - 1);

`ifdef ULA_CTRL_WATCHDOG_EN
  localparam bit WatchdogEn = 1'b1;
`else
  localparam bit WatchdogEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StFlush, StLaunch, StArm, StRun, StFinish
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q;
  logic [23:0] counter_q, counter_d;
  logic [1:0]  status_d;
  logic        pulse_d;
  logic        accept;
  logic        timeout;

  function automatic logic op_is_valid(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b1000, 4'b1001, 4'b1010, 4'b1011: op_is_valid = 1'b1;
      default:                            op_is_valid = 1'b0;
    endcase
  endfunction

  assign accept  = cmd_valid && cmd_ready;
  assign timeout = WatchdogEn && ((state_q == StArm) || (state_q == StRun)) &&
                   (counter_q == TIMEOUT_CYCLES - 24'd1);

  always_comb begin
    counter_d = counter_q;
    case (state_q)
      StLaunch:     counter_d = '0;
      StArm, StRun: if (counter_q != '1) counter_d = counter_q + 24'd1;
      default:      counter_d = counter_q;
    endcase
  end

  // In ARM a high ula_done is stale; only a 0 sample lets the operation move to RUN.
  always_comb begin
    state_d  = state_q;
    status_d = status;
    pulse_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_is_valid(cmd_op)) begin
            state_d = StFlush;
          end else begin
            status_d = 2'b01;
            pulse_d  = 1'b1;
          end
        end
      end
      StFlush: begin
        if (abort) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end else if (flush_cnt_q == FlushLast) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (abort) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end else begin
          state_d = StArm;
        end
      end
      StArm: begin
        if (timeout) begin
          state_d  = StFinish;
          status_d = 2'b10;
        end else if (abort) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end else if (!ula_done) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (ula_done) begin
          state_d  = StFinish;
          status_d = 2'b00;
        end else if (timeout) begin
          state_d  = StFinish;
          status_d = 2'b10;
        end else if (abort) begin
          state_d  = StFinish;
          status_d = 2'b11;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (state_d == StFinish) pulse_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
      counter_q   <= '0;
      ula_seletor <= IdleCode;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      status      <= 2'b00;
      last_op     <= IdleCode;
      cycle_count <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      status      <= status_d;
      done_pulse  <= pulse_d;
      cmd_ready   <= (state_d == StIdle);
      busy        <= (state_d != StIdle);
      flush_cnt_q <= (state_q == StFlush) ? flush_cnt_q + 4'd1 : 4'd0;
      ula_seletor <= ((state_d == StLaunch) || (state_d == StArm) || (state_d == StRun)) ?
                     last_op : IdleCode;
      if (accept && op_is_valid(cmd_op)) last_op <= cmd_op;
      if (state_d == StFinish) cycle_count <= counter_d;
    end
  end

endmodule
